// File: rtl/vga_pixel_fetch.sv
// -----------------------------------------------------------------------------
// vga_pixel_fetch
//   Turns a one-cycle fetch request from the VGA write stage into a single word
//   read from the displayed frame buffer. The word comes back on vga_pixel with
//   a one-cycle done_vga pulse. Two frame buffers are supported. A display
//   swap is requested with frame_flag. The swap takes effect on the first
//   accepted request for pixel (0,0), so a frame is never displayed half from
//   each buffer.
//
//   Parameters
//     BASE0, BASE1  word addresses of frame buffers 0 and 1
//     LINE_WORDS    36-bit words per display line (two 18-bit pixels per word)
//
//   Ports
//     clock            system clock, rising edge
//     reset_b          asynchronous active-low reset
//     frame_flag       pulse: request a display-buffer swap
//     vga_flag         pulse: fetch request for (clocked_hcount, clocked_vcount)
//     clocked_hcount   pixel column of the request
//     clocked_vcount   line number of the request
//     mem_req          read request to the memory arbiter
//     mem_addr         word address, valid while mem_req=1
//     mem_ack          arbiter accepted the request this cycle
//     mem_rdata        read data word
//     mem_rvalid       mem_rdata valid this cycle
//     vga_pixel        returned word, [35:18] odd pixel, [17:0] even pixel
//     done_vga         pulse: vga_pixel updated this cycle
//     miss_count       saturating count of requests dropped while busy
//     disp_buf         buffer currently displayed (0=BASE0, 1=BASE1)
//
//   Build option
//     VGA_FETCH_BLANK_EN  when defined, requests outside the 640x480 visible
//                         area are not fetched. They return a zero word one
//                         cycle later.
//
//   Latency, counted inclusively from the vga_flag cycle to the done_vga
//   cycle, is 3 cycles plus any ack wait plus any read latency.
// -----------------------------------------------------------------------------
`default_nettype none

module vga_pixel_fetch #(
  parameter logic [18:0] BASE0      = 19'h00000,
  parameter logic [18:0] BASE1      = 19'h40000,
  parameter int unsigned LINE_WORDS = 320
) (
  input  logic        clock,
  input  logic        reset_b,
  input  logic        frame_flag,
  input  logic        vga_flag,
  input  logic [9:0]  clocked_hcount,
  input  logic [9:0]  clocked_vcount,
  output logic        mem_req,
  output logic [18:0] mem_addr,
  input  logic        mem_ack,
  input  logic [35:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [35:0] vga_pixel,
  output logic        done_vga,
  output logic [7:0]  miss_count,
  output logic        disp_buf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]  state_q,     state_d;
  logic        mem_req_q,   mem_req_d;
  logic [18:0] mem_addr_q,  mem_addr_d;
  logic [35:0] vga_pixel_q, vga_pixel_d;
  logic        done_q,      done_d;
  logic [7:0]  miss_q,      miss_d;
  logic        disp_buf_q,  disp_buf_d;
  logic        swap_pend_q, swap_pend_d;
  logic        blank_s;
  logic        unused_s;

  // Two pixels share a word, so the pixel-select bit of hcount is not used.
  assign unused_s = clocked_hcount[0];

  // Word address of the pixel pair. The 320-word line uses shifts only.
  function automatic logic [18:0] fetch_addr(input logic       sel,
                                             input logic [9:0] h,
                                             input logic [9:0] v);
    logic [18:0] v_ext;
    logic [18:0] line_off;
    v_ext = {9'd0, v};
    if (LINE_WORDS == 32'd320) begin
      line_off = (v_ext << 8) + (v_ext << 6);
    end else begin
      line_off = v_ext * 19'(LINE_WORDS);
    end
    fetch_addr = (sel ? BASE1 : BASE0) + line_off + {10'd0, h[9:1]};
  endfunction

`ifdef VGA_FETCH_BLANK_EN
  // Coordinates outside the visible area are answered without a memory read.
  assign blank_s = (clocked_hcount >= 10'd640) || (clocked_vcount >= 10'd480);
`else
  assign blank_s = 1'b0;
`endif

  // Next-state logic for the fetch FSM, swap control and miss counter.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    vga_pixel_d = vga_pixel_q;
    done_d      = 1'b0;
    miss_d      = miss_q;
    disp_buf_d  = disp_buf_q;
    swap_pend_d = swap_pend_q | frame_flag;

    // A request that arrives while a fetch is in flight is dropped and counted.
    if (vga_flag && (state_q != S_IDLE)) begin
      if (miss_q != 8'hFF) begin
        miss_d = miss_q + 8'd1;
      end else begin
        miss_d = miss_q;
      end
    end else begin
      miss_d = miss_q;
    end

    case (state_q)
      S_IDLE: begin
        if (vga_flag) begin
          if (blank_s) begin
            vga_pixel_d = 36'd0;
            done_d      = 1'b1;
          end else begin
            // The swap lands on the first pixel of a frame. That request
            // already reads from the new buffer.
            if (swap_pend_q && (clocked_hcount == 10'd0) && (clocked_vcount == 10'd0)) begin
              disp_buf_d  = ~disp_buf_q;
              swap_pend_d = 1'b0;
            end else begin
              disp_buf_d  = disp_buf_q;
            end
            mem_addr_d = fetch_addr(disp_buf_d, clocked_hcount, clocked_vcount);
            mem_req_d  = 1'b1;
            state_d    = S_REQ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          // Zero-latency arbiters return data with the ack itself.
          if (mem_rvalid) begin
            vga_pixel_d = mem_rdata;
            done_d      = 1'b1;
            state_d     = S_IDLE;
          end else begin
            state_d     = S_WAIT;
          end
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          vga_pixel_d = mem_rdata;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 19'd0;
      vga_pixel_q <= 36'd0;
      done_q      <= 1'b0;
      miss_q      <= 8'd0;
      disp_buf_q  <= 1'b0;
      swap_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      vga_pixel_q <= vga_pixel_d;
      done_q      <= done_d;
      miss_q      <= miss_d;
      disp_buf_q  <= disp_buf_d;
      swap_pend_q <= swap_pend_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign vga_pixel  = vga_pixel_q;
  assign done_vga   = done_q;
  assign miss_count = miss_q;
  assign disp_buf   = disp_buf_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_pixel_fetch.sv
// -----------------------------------------------------------------------------
// tb_vga_pixel_fetch
//   Table of fetch requests with the addresses, data and buffer selection
//   expected for each. A scoreboard queue of expected vga_pixel words is filled
//   when a request is issued and drained by a monitor on each done_vga pulse.
//   Hand-written sequences cover the reset state, dropped requests, the blank
//   option, and reset in the middle of a transaction.
// -----------------------------------------------------------------------------
module tb_vga_pixel_fetch;

  logic        clock;
  logic        reset_b;
  logic        frame_flag;
  logic        vga_flag;
  logic [9:0]  clocked_hcount;
  logic [9:0]  clocked_vcount;
  logic        mem_req;
  logic [18:0] mem_addr;
  logic        mem_ack;
  logic [35:0] mem_rdata;
  logic        mem_rvalid;
  logic [35:0] vga_pixel;
  logic        done_vga;
  logic [7:0]  miss_count;
  logic        disp_buf;

  vga_pixel_fetch dut (
    .clock          (clock),
    .reset_b        (reset_b),
    .frame_flag     (frame_flag),
    .vga_flag       (vga_flag),
    .clocked_hcount (clocked_hcount),
    .clocked_vcount (clocked_vcount),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .mem_rvalid     (mem_rvalid),
    .vga_pixel      (vga_pixel),
    .done_vga       (done_vga),
    .miss_count     (miss_count),
    .disp_buf       (disp_buf)
  );

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    int          nff;      // frame_flag pulses before the request
    int          ack_dly;  // cycles mem_ack is withheld
    int          rd_dly;   // cycles from ack to rvalid (0 = same cycle)
    logic [35:0] rdata;
    logic [18:0] addr;
    logic        buf_exp;
  } vec_t;

  int          n_vec;
  int          n_miss;
  int          cyc;
  int          done_cnt;
  int          done_cyc;
  logic [35:0] sb[$];
  vec_t        vecs[10];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done_vga pulse must match the oldest expected word.
  always @(negedge clock) begin
    if (done_vga === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        check("vga_pixel", 64'(vga_pixel), 64'(sb.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_vec(input vec_t t, input string tag);
    int   dn0;
    int   flag_cyc;
    logic stable_ok;
    for (int i = 0; i < t.nff; i++) begin
      frame_flag = 1'b1;
      tick();
      frame_flag = 1'b0;
      tick();
    end
    clocked_hcount = t.h;
    clocked_vcount = t.v;
    vga_flag       = 1'b1;
    mem_rdata      = ~t.rdata;
    sb.push_back(t.rdata);
    dn0 = done_cnt;
    tick();
    vga_flag = 1'b0;
    flag_cyc = cyc;
    check({tag, "_req"},  64'(mem_req),  64'd1);
    check({tag, "_addr"}, 64'(mem_addr), 64'(t.addr));
    check({tag, "_buf"},  64'(disp_buf), 64'(t.buf_exp));
    stable_ok = 1'b1;
    for (int i = 0; i < t.ack_dly; i++) begin
      tick();
      if ((mem_req !== 1'b1) || (mem_addr !== t.addr)) stable_ok = 1'b0;
    end
    mem_ack    = 1'b1;
    mem_rvalid = (t.rd_dly == 0);
    mem_rdata  = (t.rd_dly == 0) ? t.rdata : ~t.rdata;
    tick();
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    check({tag, "_req_drop"}, 64'(mem_req), 64'd0);
    if (t.rd_dly > 0) begin
      for (int i = 1; i < t.rd_dly; i++) tick();
      mem_rvalid = 1'b1;
      mem_rdata  = t.rdata;
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = ~t.rdata;
    end
    check({tag, "_done"}, 64'(done_vga), 64'd1);
    tick();
    tick();
    check({tag, "_done_once"}, 64'(done_cnt - dn0), 64'd1);
    check({tag, "_latency"},   64'(done_cyc - flag_cyc), 64'(1 + t.ack_dly + t.rd_dly));
    check({tag, "_hold"},      64'(vga_pixel), 64'(t.rdata));
    check({tag, "_stable"},    64'(stable_ok), 64'd1);
  endtask

  initial begin
    vec_t t;
    int   dn0;
    logic req_bad;

    n_vec = 0; n_miss = 0; cyc = 0; done_cnt = 0; done_cyc = 0;
    reset_b = 1'b1; frame_flag = 1'b0; vga_flag = 1'b0;
    clocked_hcount = 10'd0; clocked_vcount = 10'd0;
    mem_ack = 1'b0; mem_rdata = 36'd0; mem_rvalid = 1'b0;

    //            h        v        nff ack rd  rdata           addr        buf
    vecs[0] = '{10'd5,   10'd2,   0,  0,  1,  36'h123456789, 19'h00282, 1'b0};
    vecs[1] = '{10'd100, 10'd10,  0,  4,  2,  36'hABCDE1234, 19'h00CB2, 1'b0};
    vecs[2] = '{10'd639, 10'd0,   0,  0,  0,  36'hFFFFFFFFF, 19'h0013F, 1'b0};
    vecs[3] = '{10'd0,   10'd0,   1,  1,  1,  36'h000000001, 19'h40000, 1'b1};
    vecs[4] = '{10'd639, 10'd479, 0,  2,  0,  36'h2AAAA5555, 19'h657FF, 1'b1};
    vecs[5] = '{10'd1,   10'd1,   0,  0,  3,  36'h800000001, 19'h40140, 1'b1};
    vecs[6] = '{10'd4,   10'd0,   1,  0,  1,  36'h0F0F0F0F0, 19'h40002, 1'b1};
    vecs[7] = '{10'd0,   10'd0,   0,  0,  1,  36'h111111111, 19'h00000, 1'b0};
    vecs[8] = '{10'd0,   10'd0,   2,  1,  0,  36'h5A5A5A5A5, 19'h40000, 1'b1};
    vecs[9] = '{10'd0,   10'd0,   0,  0,  1,  36'h3C3C3C3C3, 19'h40000, 1'b1};

    // Reset state
    #2 reset_b = 1'b0;
    tick(); tick();
    check("rst_req",  64'(mem_req),    64'd0);
    check("rst_addr", 64'(mem_addr),   64'd0);
    check("rst_pix",  64'(vga_pixel),  64'd0);
    check("rst_done", 64'(done_vga),   64'd0);
    check("rst_miss", 64'(miss_count), 64'd0);
    check("rst_buf",  64'(disp_buf),   64'd0);
    reset_b = 1'b1;
    tick();

    // Dropped requests while busy, and rvalid without ack ignored in REQ
    clocked_hcount = 10'd3; clocked_vcount = 10'd0; vga_flag = 1'b1;
    sb.push_back(36'h0A5A5A5A5);
    dn0 = done_cnt;
    tick();
    vga_flag = 1'b0;
    check("miss_addr", 64'(mem_addr), 64'h00001);
    mem_rvalid = 1'b1; mem_rdata = 36'hBADBADBAD;
    tick();
    mem_rvalid = 1'b0;
    check("rv_no_ack_done", 64'(done_vga), 64'd0);
    check("rv_no_ack_req",  64'(mem_req),  64'd1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    req_bad = 1'b0;
    vga_flag = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem_req !== 1'b0) req_bad = 1'b1;
    end
    check("miss_5", 64'(miss_count), 64'd5);
    for (int i = 0; i < 295; i++) begin
      tick();
      if (mem_req !== 1'b0) req_bad = 1'b1;
    end
    vga_flag = 1'b0;
    check("miss_sat",    64'(miss_count), 64'hFF);
    check("miss_no_req", 64'(req_bad),    64'd0);
    mem_rvalid = 1'b1; mem_rdata = 36'h0A5A5A5A5;
    tick();
    mem_rvalid = 1'b0;
    check("miss_done", 64'(done_vga), 64'd1);
    tick(); tick();
    check("miss_done_once", 64'(done_cnt - dn0), 64'd1);

    // Table
    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

`ifdef VGA_FETCH_BLANK_EN
    // Out-of-area request: answered with zero, no memory read
    clocked_hcount = 10'd700; clocked_vcount = 10'd5; vga_flag = 1'b1;
    sb.push_back(36'd0);
    dn0 = done_cnt;
    tick();
    vga_flag = 1'b0;
    check("blank_req",  64'(mem_req),   64'd0);
    check("blank_done", 64'(done_vga),  64'd1);
    check("blank_pix",  64'(vga_pixel), 64'd0);
    tick();
    check("blank_req2", 64'(mem_req), 64'd0);
    tick();
    check("blank_once", 64'(done_cnt - dn0), 64'd1);
    t = '{10'd2, 10'd0, 0, 0, 1, 36'h246813579, 19'h40001, 1'b1};
    run_vec(t, "after_blank");
`else
    // Out-of-area coordinates are still fetched; the address wraps at 19 bits
    t = '{10'd700, 10'd5, 0, 1, 1, 36'h13579BDF0, 19'h4079E, 1'b1};
    run_vec(t, "h700");
    t = '{10'd1023, 10'd1023, 0, 0, 2, 36'hFEDCBA987, 19'h100BF, 1'b1};
    run_vec(t, "wrap");
`endif

    // Reset in the middle of REQ with a swap pending, then a late rvalid
    frame_flag = 1'b1;
    tick();
    frame_flag = 1'b0;
    clocked_hcount = 10'd5; clocked_vcount = 10'd2; vga_flag = 1'b1;
    dn0 = done_cnt;
    tick();
    vga_flag = 1'b0;
    check("mid_req", 64'(mem_req), 64'd1);
    #2 reset_b = 1'b0;
    #1;
    check("mid_rst_req",  64'(mem_req),    64'd0);
    check("mid_rst_addr", 64'(mem_addr),   64'd0);
    check("mid_rst_pix",  64'(vga_pixel),  64'd0);
    check("mid_rst_done", 64'(done_vga),   64'd0);
    check("mid_rst_miss", 64'(miss_count), 64'd0);
    check("mid_rst_buf",  64'(disp_buf),   64'd0);
    tick(); tick();
    reset_b = 1'b1;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 36'h777777777;
    tick();
    mem_rvalid = 1'b0;
    tick();
    check("late_rv_done", 64'(done_cnt - dn0), 64'd0);
    check("late_rv_pix",  64'(vga_pixel),      64'd0);
    check("late_rv_req",  64'(mem_req),        64'd0);
    t = '{10'd0, 10'd0, 0, 0, 1, 36'h0C0FFEE00, 19'h00000, 1'b0};
    run_vec(t, "post_rst");

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
